// File: rtl/sisc_pkg.sv
// Shared SISC definitions: core opcodes, bus widths and loader state encoding.
package sisc_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned IMEM_AW   = 16;
    localparam int unsigned HDR_BYTES = 2;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;

    typedef enum logic [2:0] {
        LD_IDLE   = 3'd0,
        LD_LEN_HI = 3'd1,
        LD_LEN_LO = 3'd2,
        LD_DATA   = 3'd3,
        LD_CHK    = 3'd4,
        LD_DONE   = 3'd5
    } ldr_state_e;

endpackage

// File: rtl/byte_packer.sv
// Big-endian 8-to-32 assembler: first byte of a word lands in [31:24].
module byte_packer
    import sisc_pkg::*;
(
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [WORD_W-1:0] o_word_c,
    output logic              o_word_done_c
);

    localparam int unsigned SHIFT_W = WORD_W - BYTE_W;

    logic [SHIFT_W-1:0] r_shift;
    logic [1:0]         r_idx;

    // Shift in accepted bytes and track position within the current word
    always_ff @(posedge clk) begin
        if (i_rst || i_clr) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_en) begin
            r_shift <= {r_shift[SHIFT_W-BYTE_W-1:0], i_byte};
            r_idx   <= r_idx + 2'd1;
        end
    end

    assign o_word_c      = {r_shift, i_byte};
    assign o_word_done_c = i_en && (r_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, checksummed program image into instruction memory
// and releases the SISC core from reset only after a clean load.
module imem_loader
    import sisc_pkg::*;
#(
    parameter logic [IMEM_AW-1:0] BASE_ADDR = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [BYTE_W-1:0]  in_data,
    output logic               in_ready,
    output logic               im_we,
    output logic [IMEM_AW-1:0] im_addr,
    output logic [WORD_W-1:0]  im_wdata,
    output logic               done,
    output logic               err,
    output logic               cpu_rst_f
);

    localparam int unsigned LEN_W = HDR_BYTES * BYTE_W;

    ldr_state_e         r_state;
    ldr_state_e         w_state_nxt;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_word_cnt;
    logic [BYTE_W-1:0]  r_chk;
    logic               r_im_we;
    logic [IMEM_AW-1:0] r_im_addr;
    logic [WORD_W-1:0]  r_im_wdata;
    logic               r_done;
    logic               r_err;
    logic               r_cpu_rst_f;

    logic               w_accept;
    logic               w_enter_hdr;
    logic               w_pack_en;
    logic               w_last_word;
    logic [WORD_W-1:0]  w_word_c;
    logic               w_word_done_c;

    assign in_ready    = (r_state == LD_LEN_HI) || (r_state == LD_LEN_LO) ||
                         (r_state == LD_DATA)   || (r_state == LD_CHK);
    assign w_accept    = in_valid && in_ready;
    assign w_enter_hdr = start && ((r_state == LD_IDLE) || (r_state == LD_DONE));
    assign w_pack_en   = w_accept && (r_state == LD_DATA);
    assign w_last_word = (r_word_cnt == LEN_W'(r_len - LEN_W'(1)));

    byte_packer u_packer (
        .clk           (clk),
        .i_rst         (rst),
        .i_clr         (w_enter_hdr),
        .i_en          (w_pack_en),
        .i_byte        (in_data),
        .o_word_c      (w_word_c),
        .o_word_done_c (w_word_done_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            LD_IDLE:   if (start) w_state_nxt = LD_LEN_HI;
            LD_LEN_HI: if (w_accept) w_state_nxt = LD_LEN_LO;
            LD_LEN_LO: begin
                if (w_accept) begin
                    w_state_nxt = ({r_len[BYTE_W-1:0], in_data} == '0) ? LD_CHK : LD_DATA;
                end
            end
            LD_DATA:   if (w_word_done_c && w_last_word) w_state_nxt = LD_CHK;
            LD_CHK:    if (w_accept) w_state_nxt = LD_DONE;
            LD_DONE:   if (start) w_state_nxt = LD_LEN_HI;
            default:   w_state_nxt = LD_IDLE;
        endcase
    end

    // Header capture, checksum, word writes and session status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_chk       <= '0;
            r_im_we     <= 1'b0;
            r_im_addr   <= '0;
            r_im_wdata  <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_rst_f <= 1'b0;
        end else begin
            r_im_we <= 1'b0;
            if (w_enter_hdr) begin
                r_len       <= '0;
                r_word_cnt  <= '0;
                r_chk       <= '0;
                r_done      <= 1'b0;
                r_err       <= 1'b0;
                r_cpu_rst_f <= 1'b0;
            end
            if (w_accept) begin
                unique case (r_state)
                    LD_LEN_HI, LD_LEN_LO: begin
                        r_len <= {r_len[LEN_W-BYTE_W-1:0], in_data};
                        r_chk <= r_chk ^ in_data;
                    end
                    LD_DATA: begin
                        r_chk <= r_chk ^ in_data;
                        if (w_word_done_c) begin
                            r_im_we    <= 1'b1;
                            r_im_addr  <= IMEM_AW'(BASE_ADDR + r_word_cnt);
                            r_im_wdata <= w_word_c;
                            r_word_cnt <= r_word_cnt + LEN_W'(1);
                        end
                    end
                    LD_CHK: begin
                        r_done      <= 1'b1;
                        r_err       <= (in_data != r_chk);
                        r_cpu_rst_f <= (in_data == r_chk);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign im_we     = r_im_we;
    assign im_addr   = r_im_addr;
    assign im_wdata  = r_im_wdata;
    assign done      = r_done;
    assign err       = r_err;
    assign cpu_rst_f = r_cpu_rst_f;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench: two loaders (base 0000 and FFFF) share one byte stream.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        w_rdy   [2];
    logic        w_we    [2];
    logic [15:0] w_addr  [2];
    logic [31:0] w_wdata [2];
    logic        w_done  [2];
    logic        w_err   [2];
    logic        w_cpu   [2];

    logic [15:0] bases [2] = '{16'h0000, 16'hFFFF};

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx [$];
    logic [31:0] wq [$];

    logic [15:0] wa [2][64];
    logic [31:0] wd [2][64];
    int          wn [2];
    int          hold_viol [2];
    logic [15:0] last_a [2];
    logic [31:0] last_d [2];
    logic        rst_q = 1'b1;

    always #5 clk = ~clk;

    imem_loader #(.BASE_ADDR(16'h0000)) dut0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(w_rdy[0]), .im_we(w_we[0]), .im_addr(w_addr[0]), .im_wdata(w_wdata[0]),
        .done(w_done[0]), .err(w_err[0]), .cpu_rst_f(w_cpu[0])
    );

    imem_loader #(.BASE_ADDR(16'hFFFF)) dut1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(w_rdy[1]), .im_we(w_we[1]), .im_addr(w_addr[1]), .im_wdata(w_wdata[1]),
        .done(w_done[1]), .err(w_err[1]), .cpu_rst_f(w_cpu[1])
    );

    always @(posedge clk) rst_q <= rst;

    // Record every memory write; outside writes the address/data must hold
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_q) begin
                last_a[d] = w_addr[d];
                last_d[d] = w_wdata[d];
            end else if (w_we[d] === 1'b1) begin
                if (wn[d] < 64) begin
                    wa[d][wn[d]] = w_addr[d];
                    wd[d][wn[d]] = w_wdata[d];
                end
                wn[d]++;
                last_a[d] = w_addr[d];
                last_d[d] = w_wdata[d];
            end else if (w_addr[d] !== last_a[d] || w_wdata[d] !== last_d[d]) begin
                hold_viol[d]++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic clk_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        in_valid = 1'b1;
        in_data  = b;
        for (t = 0; t < 20 && w_rdy[0] !== 1'b1; t++) clk_cycle();
        checks++;
        if (w_rdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL send_byte in_ready got=%b want=1", w_rdy[0]);
        end
        clk_cycle();
        in_valid = 1'b0;
    endtask

    // Stream = N (big-endian) | words (big-endian) | checksum; checksum is XOR of all prior bytes
    task automatic build_stream(input logic force_chk, input logic [7:0] chk_val);
        int n;
        logic [7:0] x;
        n = wq.size();
        tx.delete();
        tx.push_back(8'(n >> 8));
        tx.push_back(8'(n));
        foreach (wq[k]) begin
            tx.push_back(wq[k][31:24]);
            tx.push_back(wq[k][23:16]);
            tx.push_back(wq[k][15:8]);
            tx.push_back(wq[k][7:0]);
        end
        x = 8'h00;
        foreach (tx[i]) x ^= tx[i];
        tx.push_back(force_chk ? chk_val : x);
    endtask

    // Drives one session from IDLE/DONE and checks it against the stream-derived model
    task automatic run_session(input string name, input int gap, input int start_at);
        int n;
        logic [7:0]  x;
        logic        exp_err;
        logic [15:0] ea;
        logic [31:0] ew;
        wn[0] = 0;
        wn[1] = 0;
        start = 1'b1;
        clk_cycle();
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (w_rdy[d] !== 1'b1 || w_done[d] !== 1'b0 || w_cpu[d] !== 1'b0 || w_err[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s dut%0d session-open rdy/done/err/cpu got=%b%b%b%b want=1000",
                         name, d, w_rdy[d], w_done[d], w_err[d], w_cpu[d]);
            end
        end
        for (int i = 0; i < tx.size(); i++) begin
            if (gap != 0 && i > 0) begin
                in_valid = 1'b0;
                if (i == start_at) start = 1'b1;
                clk_cycle();
                start = 1'b0;
            end
            send_byte(tx[i]);
        end
        in_valid = 1'b0;
        clk_cycle();
        clk_cycle();
        n = int'({tx[0], tx[1]});
        x = 8'h00;
        for (int i = 0; i < tx.size() - 1; i++) x ^= tx[i];
        exp_err = (x != tx[tx.size() - 1]);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (wn[d] != n) begin
                errors++;
                $display("FAIL %s dut%0d write count got=%0d want=%0d", name, d, wn[d], n);
            end
            for (int k = 0; k < n && k < wn[d] && k < 64; k++) begin
                ea = 16'(bases[d] + 16'(k));
                ew = {tx[2 + 4*k], tx[3 + 4*k], tx[4 + 4*k], tx[5 + 4*k]};
                checks++;
                if (wa[d][k] !== ea || wd[d][k] !== ew) begin
                    errors++;
                    $display("FAIL %s dut%0d write%0d got=%h:%h want=%h:%h",
                             name, d, k, wa[d][k], wd[d][k], ea, ew);
                end
            end
            checks++;
            if (w_done[d] !== 1'b1 || w_err[d] !== exp_err || w_cpu[d] !== !exp_err || w_rdy[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s dut%0d done/err/cpu/rdy got=%b%b%b%b want=1%b%b0",
                         name, d, w_done[d], w_err[d], w_cpu[d], w_rdy[d], exp_err, !exp_err);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        clk_cycle();
        clk_cycle();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (w_we[d] !== 1'b0 || w_addr[d] !== 16'h0000 || w_wdata[d] !== 32'h0 ||
                w_done[d] !== 1'b0 || w_err[d] !== 1'b0 || w_cpu[d] !== 1'b0 || w_rdy[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d we/addr/wdata/done/err/cpu/rdy got=%b/%h/%h/%b%b%b%b want=0/0000/00000000/0000",
                         d, w_we[d], w_addr[d], w_wdata[d], w_done[d], w_err[d], w_cpu[d], w_rdy[d]);
            end
        end
        clk_cycle();
        checks++;
        if (w_rdy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority in_ready got=%b want=0", w_rdy[0]);
        end
    endtask

    task automatic test_good_load();
        wq.delete();
        wq.push_back(32'h12345678);
        wq.push_back(32'h9ABCDEF0);
        build_stream(1'b1, 8'h02);
        run_session("good_load", 0, -1);
        checks++;
        if (w_err[0] !== 1'b0 || w_cpu[0] !== 1'b1 || wd[0][0] !== 32'h12345678 || wd[0][1] !== 32'h9ABCDEF0) begin
            errors++;
            $display("FAIL good_load err/cpu/m0/m1 got=%b%b/%h/%h want=01/12345678/9abcdef0",
                     w_err[0], w_cpu[0], wd[0][0], wd[0][1]);
        end
    endtask

    task automatic test_bad_chk();
        wq.delete();
        wq.push_back(32'h12345678);
        wq.push_back(32'h9ABCDEF0);
        build_stream(1'b1, 8'h09);
        run_session("bad_chk", 0, -1);
        checks++;
        if (w_done[0] !== 1'b1 || w_err[0] !== 1'b1 || w_cpu[0] !== 1'b0 || wn[0] != 2) begin
            errors++;
            $display("FAIL bad_chk done/err/cpu/writes got=%b%b%b/%0d want=110/2",
                     w_done[0], w_err[0], w_cpu[0], wn[0]);
        end
    endtask

    task automatic test_zero_len();
        wq.delete();
        build_stream(1'b1, 8'h00);
        run_session("zero_len", 0, -1);
        checks++;
        if (wn[0] != 0 || w_err[0] !== 1'b0 || w_cpu[0] !== 1'b1) begin
            errors++;
            $display("FAIL zero_len writes/err/cpu got=%0d/%b%b want=0/01", wn[0], w_err[0], w_cpu[0]);
        end
    endtask

    task automatic test_wrap();
        wq.delete();
        wq.push_back(32'h11111111);
        wq.push_back(32'h22222222);
        build_stream(1'b0, 8'h00);
        run_session("wrap", 0, -1);
        checks++;
        if (wa[1][0] !== 16'hFFFF || wa[1][1] !== 16'h0000 || wd[1][1] !== 32'h22222222 || w_err[1] !== 1'b0) begin
            errors++;
            $display("FAIL wrap addr0/addr1/data1/err got=%h/%h/%h/%b want=ffff/0000/22222222/0",
                     wa[1][0], wa[1][1], wd[1][1], w_err[1]);
        end
    endtask

    task automatic test_throttle_start();
        wq.delete();
        wq.push_back(32'h12345678);
        wq.push_back(32'h9ABCDEF0);
        build_stream(1'b0, 8'h00);
        run_session("throttle_start", 1, 5);
        checks++;
        if (wn[0] != 2 || wa[0][1] !== 16'h0001 || wd[0][1] !== 32'h9ABCDEF0 || w_done[0] !== 1'b1) begin
            errors++;
            $display("FAIL throttle_start writes/addr1/data1/done got=%0d/%h/%h/%b want=2/0001/9abcdef0/1",
                     wn[0], wa[0][1], wd[0][1], w_done[0]);
        end
    endtask

    task automatic test_reset_midload();
        wq.delete();
        wq.push_back(32'h12345678);
        wq.push_back(32'h9ABCDEF0);
        build_stream(1'b0, 8'h00);
        wn[0] = 0;
        wn[1] = 0;
        start = 1'b1;
        clk_cycle();
        start = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(tx[i]);
        clk_cycle();
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
        clk_cycle();
        rst = 1'b0; in_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (w_done[d] !== 1'b0 || w_cpu[d] !== 1'b0 || w_rdy[d] !== 1'b0 || w_we[d] !== 1'b0 || w_addr[d] !== 16'h0000) begin
                errors++;
                $display("FAIL midreset dut%0d done/cpu/rdy/we/addr got=%b%b%b%b/%h want=0000/0000",
                         d, w_done[d], w_cpu[d], w_rdy[d], w_we[d], w_addr[d]);
            end
        end
        for (int i = 0; i < 6; i++) clk_cycle();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (wn[d] != 1 || wd[d][0] !== 32'h12345678 || wa[d][0] !== bases[d]) begin
                errors++;
                $display("FAIL midreset dut%0d writes/data0/addr0 got=%0d/%h/%h want=1/12345678/%h",
                         d, wn[d], wd[d][0], wa[d][0], bases[d]);
            end
        end
        run_session("after_midreset", 0, -1);
    endtask

    task automatic test_random();
        int n;
        int gap;
        for (int s = 0; s < 8; s++) begin
            n   = int'($urandom_range(0, 6));
            gap = int'($urandom_range(0, 1));
            wq.delete();
            for (int k = 0; k < n; k++) wq.push_back($urandom);
            build_stream(1'b0, 8'h00);
            if ($urandom_range(0, 1) == 1) tx[tx.size() - 1] ^= 8'($urandom_range(1, 255));
            run_session("random", gap, int'($urandom_range(1, 30)));
        end
    endtask

    task automatic test_hold_stable();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (hold_viol[d] != 0) begin
                errors++;
                $display("FAIL hold_stable dut%0d changes-without-we got=%0d want=0", d, hold_viol[d]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        wn[0] = 0; wn[1] = 0;
        hold_viol[0] = 0; hold_viol[1] = 0;
        test_reset();
        test_good_load();
        test_bad_chk();
        test_zero_len();
        test_wrap();
        test_throttle_start();
        test_reset_midload();
        test_random();
        test_hold_stable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
